// File: rtl/bcd_display_decoder.sv
// BCD entry register with a time-multiplexed common-cathode 7-segment scan.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank unentered leading positions.
module bcd_display_decoder #(
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [3:0]                 bcd,
  input  logic                       valid,
  input  logic                       clear,
  output logic [6:0]                 seg,
  output logic [NDIG-1:0]            an,
  output logic [4*NDIG-1:0]          digits,
  output logic [$clog2(NDIG+1)-1:0]  count,
  output logic                       err
);

  localparam int CW = $clog2(NDIG+1);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NDIG);

  logic [4*NDIG-1:0] digits_r, digits_s;
  logic [CW-1:0]     count_r, count_s;
  logic              err_r, err_s;
  logic [PW-1:0]     presc_r, presc_s;
  logic [IW-1:0]     idx_r, idx_s;
  logic [6:0]        seg_r, seg_s;
  logic [NDIG-1:0]   an_r, an_s;
  logic [3:0]        digit_s;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Entry register: clear has priority, invalid codes only raise the sticky flag.
  always_comb begin
    digits_s = digits_r;
    count_s  = count_r;
    err_s    = err_r;
    if (clear) begin
      digits_s = {(4*NDIG){1'b0}};
      count_s  = {CW{1'b0}};
      err_s    = 1'b0;
    end else if (valid) begin
      if (bcd <= 4'd9) begin
        digits_s = {digits_r[4*NDIG-5:0], bcd};
        if (count_r == CW'(NDIG)) begin
          count_s = count_r;
        end else begin
          count_s = count_r + CW'(1);
        end
      end else begin
        err_s = 1'b1;
      end
    end else begin
      digits_s = digits_r;
    end
  end

  // Scan prescaler and digit index, independent of entry activity.
  always_comb begin
    if (presc_r == PW'(SCAN_DIV-1)) begin
      presc_s = {PW{1'b0}};
      if (idx_r == IW'(NDIG-1)) begin
        idx_s = {IW{1'b0}};
      end else begin
        idx_s = idx_r + IW'(1);
      end
    end else begin
      presc_s = presc_r + PW'(1);
      idx_s   = idx_r;
    end
  end

  // Output stage inputs: digit enable and segment pattern for the current index.
  always_comb begin
    digit_s = digits_r[4*int'(idx_r) +: 4];
    an_s    = NDIG'(1) << idx_r;
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx_r != IW'(0)) && (int'(idx_r) >= int'(count_r))) begin
      seg_s = 7'h00;
    end else begin
      seg_s = seg_decode(digit_s);
    end
`else
    seg_s = seg_decode(digit_s);
`endif
  end

  // Entry state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_r <= {(4*NDIG){1'b0}};
      count_r  <= {CW{1'b0}};
      err_r    <= 1'b0;
    end else begin
      digits_r <= digits_s;
      count_r  <= count_s;
      err_r    <= err_s;
    end
  end

  // Scan state and registered display outputs; an/seg follow idx by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= {PW{1'b0}};
      idx_r   <= {IW{1'b0}};
      an_r    <= NDIG'(1);
      seg_r   <= 7'h3F;
    end else begin
      presc_r <= presc_s;
      idx_r   <= idx_s;
      an_r    <= an_s;
      seg_r   <= seg_s;
    end
  end

  assign seg    = seg_r;
  assign an     = an_r;
  assign digits = digits_r;
  assign count  = count_r;
  assign err    = err_r;

endmodule
